// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the write-back entry layout used by the
// GRF write-back queue and its bench.
package cpu_pkg;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/grf_wb_queue_if.sv
// Bundle of producer, GRF write-port and forwarding-lookup signals around the
// write-back queue. The queue side uses the slave modport.
interface grf_wb_queue_if #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int CW = 3
);
  // Producer handshake: a request transfers on the rising edge where
  // in_valid && in_ready; in_pc/in_addr/in_data must be stable while in_valid.
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          grf_hold;
  logic          grf_we;
  logic [DW-1:0] grf_pc;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd;
  logic [AW-1:0] q_a1;
  logic [AW-1:0] q_a2;
  logic          q_hit1;
  logic          q_hit2;
  logic [DW-1:0] q_data1;
  logic [DW-1:0] q_data2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc, in_addr, in_data, grf_hold, q_a1, q_a2,
    input  in_ready, grf_we, grf_pc, grf_a3, grf_wd,
    input  q_hit1, q_hit2, q_data1, q_data2, count
  );

  modport slave (
    input  in_valid, in_pc, in_addr, in_data, grf_hold, q_a1, q_a2,
    output in_ready, grf_we, grf_pc, grf_a3, grf_wd,
    output q_hit1, q_hit2, q_data1, q_data2, count
  );
endinterface

// File: rtl/grf_wb_match.sv
// Youngest-first address matcher over the occupied entries of the write-back
// queue; address 0 never hits.
module grf_wb_match #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0] addr_mem [DEPTH],
  input  logic [DW-1:0] data_mem [DEPTH],
  input  logic [PW-1:0] rd_ptr,
  input  logic [CW-1:0] cnt,
  input  logic [AW-1:0] q_addr,
  output logic          hit,
  output logic [DW-1:0] data
);
  logic [PW-1:0] idx;

  // Walk from head (oldest) to tail; a later match overwrites an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < cnt) && (q_addr != '0) && (addr_mem[idx] == q_addr)) begin
        hit  = 1'b1;
        data = data_mem[idx];
      end
    end
  end
endmodule

// File: rtl/grf_wb_queue.sv
// GRF write-back request queue: buffers producer writes, drains one per cycle
// into WE3/A3/WD/PC and forwards pending values. GRF_WB_QUEUE_DISPLAY_EN adds a commit log.
module grf_wb_queue #(
  parameter int DEPTH = cpu_pkg::WB_DEPTH,
  parameter int DW    = cpu_pkg::DW,
  parameter int AW    = cpu_pkg::AW
) (
  input logic           clk,
  input logic           reset,
  grf_wb_queue_if.slave bus
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic full;
  logic empty;
  logic push_acc;
  logic push;
  logic pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  // A full queue refuses even when it drains on the same edge.
  assign push_acc = bus.in_valid && !full;
  // Writes to $0 complete the handshake but are never stored.
  assign push     = push_acc && (bus.in_addr != '0);
  assign pop      = bus.grf_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.in_pc;
      addr_mem[wr_ptr] <= bus.in_addr;
      data_mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.in_ready = !full;
  assign bus.count    = cnt;
  assign bus.grf_we   = !empty && !bus.grf_hold;
  assign bus.grf_pc   = empty ? '0 : pc_mem[rd_ptr];
  assign bus.grf_a3   = empty ? '0 : addr_mem[rd_ptr];
  assign bus.grf_wd   = empty ? '0 : data_mem[rd_ptr];

  grf_wb_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_match1 (
    .addr_mem (addr_mem),
    .data_mem (data_mem),
    .rd_ptr   (rd_ptr),
    .cnt      (cnt),
    .q_addr   (bus.q_a1),
    .hit      (bus.q_hit1),
    .data     (bus.q_data1)
  );

  grf_wb_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_match2 (
    .addr_mem (addr_mem),
    .data_mem (data_mem),
    .rd_ptr   (rd_ptr),
    .cnt      (cnt),
    .q_addr   (bus.q_a2),
    .hit      (bus.q_hit2),
    .data     (bus.q_data2)
  );

`ifdef GRF_WB_QUEUE_DISPLAY_EN
  always @(posedge clk) begin
    if (bus.grf_we && !reset)
      $display("@%h: $%d <= %h", bus.grf_pc, bus.grf_a3, bus.grf_wd);
  end
`else
  // Default build carries no commit log.
`endif
endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: drivers push requests and expected GRF
// writes into a queue; a negedge monitor pops and compares every drain.
module tb_grf_wb_queue;
  import cpu_pkg::*;

  localparam int EW = $bits(wb_entry_t);

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [EW-1:0] exp_q [$];
  wb_entry_t     mon_e;

  grf_wb_queue_if #(.DW(32), .AW(5), .CW(3)) bus ();

  grf_wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drivers: called just after a rising edge, return just after a rising edge.
  task automatic push(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_addr  = addr;
    bus.in_data  = data;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        if (addr != 5'd0) exp_q.push_back({pc, addr, data});
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (bus.count != 3'd0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout_count", 32'(bus.count), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.grf_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: a3=%0d wd=%0h, expected no write", bus.grf_a3, bus.grf_wd);
      end else begin
        mon_e = wb_entry_t'(exp_q.pop_front());
        check("drain_pc", bus.grf_pc, mon_e.pc);
        check("drain_a3", 32'(bus.grf_a3), 32'(mon_e.addr));
        check("drain_wd", bus.grf_wd, mon_e.data);
      end
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pc    = '0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.grf_hold = 1'b0;
    bus.q_a1     = '0;
    bus.q_a2     = '0;
    #2;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_grf_we", 32'(bus.grf_we), 32'd0);
    check("rst_grf_wd", bus.grf_wd, 32'd0);
    check("rst_q_hit1", 32'(bus.q_hit1), 32'd0);
    check("rst_q_data1", bus.q_data1, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single push: write visible the following cycle, gone after its edge
    push(32'h3000, 5'd1, 32'd99);
    @(negedge clk);
    check("single_we", 32'(bus.grf_we), 32'd1);
    check("single_a3", 32'(bus.grf_a3), 32'd1);
    check("single_wd", bus.grf_wd, 32'd99);
    check("single_count", 32'(bus.count), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_after_count", 32'(bus.count), 32'd0);
    check("single_after_we", 32'(bus.grf_we), 32'd0);
    @(posedge clk); #1;

    // Fill under hold, refuse a fifth, then drain in order
    bus.grf_hold = 1'b1;
    for (int i = 1; i <= 4; i++)
      push(32'h3000 + 32'(4 * i), 5'(i), 32'(10 * i));
    @(negedge clk);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_hold_we", 32'(bus.grf_we), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'd50;
    @(negedge clk);
    check("fifth_refused", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("fifth_count", 32'(bus.count), 32'd4);
    bus.grf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("drain_seq_a3", 32'(bus.grf_a3), 32'(i));
      @(posedge clk); #1;
    end
    check("drain_seq_empty", 32'(bus.count), 32'd0);

    // Write to $0: accepted, never stored or written
    push(32'h3100, 5'd0, 32'd5);
    @(negedge clk);
    check("zero_count", 32'(bus.count), 32'd0);
    check("zero_we", 32'(bus.grf_we), 32'd0);
    @(posedge clk); #1;

    // Forwarding: youngest match wins, misses and $0 return 0
    bus.grf_hold = 1'b1;
    push(32'h3200, 5'd2, 32'd7);
    push(32'h3204, 5'd2, 32'd9);
    bus.q_a1 = 5'd2;
    bus.q_a2 = 5'd3;
    #1;
    check("fwd_hit1", 32'(bus.q_hit1), 32'd1);
    check("fwd_data1", bus.q_data1, 32'd9);
    check("fwd_hit2", 32'(bus.q_hit2), 32'd0);
    check("fwd_data2", bus.q_data2, 32'd0);
    bus.q_a1 = 5'd0;
    #1;
    check("fwd_zero_hit", 32'(bus.q_hit1), 32'd0);
    bus.q_a1 = 5'd2;
    @(posedge clk); #1;
    bus.grf_hold = 1'b0;
    @(negedge clk);
    check("fwd_head_draining", bus.q_data1, 32'd9);
    @(posedge clk); #1;
    wait_drain();

    // Full queue with drain active: refused this cycle, accepted next
    bus.grf_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      push(32'h3300 + 32'(4 * i), 5'(8 + i), 32'(100 + i));
    bus.grf_hold = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h3310;
    bus.in_addr  = 5'd12;
    bus.in_data  = 32'd104;
    @(negedge clk);
    check("nobypass_ready", 32'(bus.in_ready), 32'd0);
    check("nobypass_we", 32'(bus.grf_we), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("nobypass_ready_next", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) exp_q.push_back({32'h3310, 5'd12, 32'd104});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++)
      push(32'h3400 + 32'(4 * i), 5'(16 + i), 32'(1000 + 7 * i));
    wait_drain();

    // Reset mid-drain with three pending entries
    bus.grf_hold = 1'b1;
    for (int i = 0; i < 3; i++)
      push(32'h3500 + 32'(4 * i), 5'(20 + i), 32'(500 + i));
    bus.grf_hold = 1'b0;
    #2;
    check("mid_count", 32'(bus.count), 32'd3);
    check("mid_we", 32'(bus.grf_we), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_we", 32'(bus.grf_we), 32'd0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_wd", bus.grf_wd, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_count", 32'(bus.count), 32'd0);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grf_wb_queue.md
# grf_wb_queue

Write-back request queue on the initiator side of the GRF write port (WE3/A3/WD/PC). Buffers register write requests from multi-cycle producers (load unit, mult/div unit), drains them into the GRF at most one per cycle, and supplies a forwarding lookup so decode-stage reads see pending values before they reach the register file. Sits between the producers and the GRF write port of the CPU datapath.

## Interface
Parameters:
- DEPTH, 4, number of queued entries (power of two, ≥2)
- DW, 32, data/PC width
- AW, 5, register address width

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears the queue
- in_valid  in  1  producer offers a write request
- in_ready  out  1  queue can accept; transfer on `in_valid && in_ready` at rising edge
- in_pc  in  DW  PC of the producing instruction
- in_addr  in  AW  destination register
- in_data  in  DW  value to write
- grf_hold  in  1  GRF write port busy this cycle; blocks drain
- grf_we  out  1  to GRF WE3
- grf_pc  out  DW  to GRF PC
- grf_a3  out  AW  to GRF A3
- grf_wd  out  DW  to GRF WD
- q_a1, q_a2  in  AW  lookup addresses (decode-stage A1/A2)
- q_hit1, q_hit2  out  1  pending entry matches q_aN
- q_data1, q_data2  out  DW  data of matching entry (0 when no hit)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular FIFO: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), count register.
- Push: `in_valid && in_ready` at edge → entry {pc, addr, data} written at wr_ptr, wr_ptr+1, count+1.
- Writes to `$0` (in_addr == 0): accepted (handshake completes), not stored; count unchanged.
- in_ready = (count != DEPTH); no same-cycle full-bypass — a full queue refuses even if draining that edge.
- Drain: head entry drives grf_pc/grf_a3/grf_wd combinationally; grf_we = (count != 0) && !grf_hold. Pop at edge when grf_we == 1 (GRF commits the same edge).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Lookup: compare q_aN against all occupied entries; youngest matching entry wins; q_aN == 0 never hits. Head entry being drained this cycle still participates.
- grf_* data outputs are 0 when count == 0.

## Timing
- Reset (async): count=0, pointers=0; immediately grf_we=0, grf_pc/a3/wd=0, in_ready=1, q_hitN=0, q_dataN=0, count=0.
- Reset during operation discards all pending entries; no partial GRF write is issued after reset assertion.
- Latency: request accepted at edge k with empty queue → grf_we=1 during cycle k..k+1, committed to GRF at edge k+1.
- Throughput: one drain per cycle when grf_hold=0; a full queue with grf_hold=1 holds indefinitely, in_ready=0.
- Lookup outputs are combinational from queue state (same cycle).

## Configuration
- GRF_WB_QUEUE_DISPLAY_EN defined: on every edge where grf_we=1 and reset=0, `$display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd)`, matching the CPU's grading log format; simulation only.
- Undefined: no display statements; RTL otherwise identical.

## Structure
- Shared package `cpu_pkg`: AW/DW constants, entry struct typedef {pc, addr, data}.
- One sub-module: `grf_wb_match` — priority (youngest-first) address matcher, instantiated twice for q_a1/q_a2.

## Test plan
- Reset then single push {pc=0x3000, addr=1, data=99} → next cycle grf_we=1, grf_a3=1, grf_wd=99; after edge count=0, grf_we=0.
- grf_hold=1, push 4 entries (addr 1..4, data 10..40) → count=4, in_ready=0, 5th request not accepted; release hold → addrs 1,2,3,4 on four consecutive cycles.
- Push addr=0 data=5 → handshake completes, count stays 0, grf_we never asserted.
- Hold, push {addr=2,data=7} then {addr=2,data=9}; q_a1=2 → q_hit1=1, q_data1=9; q_a2=3 → q_hit2=0, q_data2=0.
- Full queue with hold=0, in_valid=1 → in_ready=0 that cycle, drain proceeds, in_ready=1 next cycle; pointer wrap exercised across 10 pushes, order preserved.
- Assert reset mid-drain with count=3 → grf_we drops to 0 before next edge, count=0, no further GRF writes.
